// File: rtl/dp_ctrl_pkg.sv
// Shared types and encodings for the datapath sequencing controller.
// Covers the FSM states, instruction fields, write-data selects and ALU operations.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WR_REG = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        IC_MOV_IMM = 3'd0,
        IC_MOV_REG = 3'd1,
        IC_MVN     = 3'd2,
        IC_ADD     = 3'd3,
        IC_CMP     = 3'd4,
        IC_AND     = 3'd5,
        IC_ILLEGAL = 3'd6
    } instr_cls_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b01;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOTB   = 2'b11;

endpackage

// File: rtl/dp_seq_ctrl_if.sv
// Instruction handshake and datapath control bundle between a sequencer and its datapath.
// The master side issues instructions; the slave side is the controller.
interface dp_seq_ctrl_if;
    import dp_ctrl_pkg::*;

    logic        start;
    logic [15:0] instr;
    logic        w;
    logic        done;
    logic        err;
    logic [2:0]  rnum;
    logic        write;
    logic [1:0]  vsel;
    logic [15:0] sximm8;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;

    modport master (
        output start, instr,
        input  w, done, err, rnum, write, vsel, sximm8,
               loada, loadb, loadc, loads, asel, shift, ALUop
    );

    modport slave (
        input  start, instr,
        output w, done, err, rnum, write, vsel, sximm8,
               loada, loadb, loadc, loads, asel, shift, ALUop
    );

endinterface

// File: rtl/dp_instr_dec.sv
// Combinational decode of the latched instruction into a class and its register fields.
// Anything outside the recognised opcode/op pairs is reported as IC_ILLEGAL.
module dp_instr_dec
    import dp_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output instr_cls_t  cls,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [1:0]  op
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    always_comb begin
        cls = IC_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = IC_MOV_IMM;
            else if (op == OP_MOV_REG) cls = IC_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = IC_ADD;
                OP_CMP:  cls = IC_CMP;
                OP_AND:  cls = IC_AND;
                default: cls = IC_MVN;
            endcase
        end
    end

endmodule

// File: rtl/dp_seq_ctrl.sv
// Multi-cycle sequencer driving register-file, operand and ALU controls for one instruction at a time.
// All control outputs are registered; each branch below loads the values for the state being entered.
module dp_seq_ctrl
    import dp_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    dp_seq_ctrl_if.slave bus
);

    state_t      state;
    logic [15:0] ir;
    instr_cls_t  cls;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh, op;

    logic        w_q, done_q, err_q, write_q;
    logic        loada_q, loadb_q, loadc_q, loads_q, asel_q;
    logic [2:0]  rnum_q;
    logic [1:0]  vsel_q, shift_q, aluop_q;

    dp_instr_dec u_dec (
        .ir  (ir),
        .cls (cls),
        .rn  (rn),
        .rd  (rd),
        .rm  (rm),
        .sh  (sh),
        .op  (op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT;
            ir      <= '0;
            w_q     <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            asel_q  <= 1'b0;
            rnum_q  <= '0;
            vsel_q  <= '0;
            shift_q <= '0;
            aluop_q <= '0;
        end else begin
            w_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            asel_q  <= 1'b0;
            rnum_q  <= '0;
            vsel_q  <= '0;
            shift_q <= '0;
            aluop_q <= '0;
            case (state)
                S_WAIT: begin
                    if (bus.start) begin
                        ir    <= bus.instr;
                        state <= S_DECODE;
                    end else begin
                        w_q   <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (cls)
                        IC_MOV_IMM: begin
                            state   <= S_WR_IMM;
                            rnum_q  <= rn;
                            vsel_q  <= VSEL_IMM;
                            write_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                        IC_MOV_REG, IC_MVN: begin
                            state   <= S_GET_B;
                            rnum_q  <= rm;
                            loadb_q <= 1'b1;
                        end
                        IC_ADD, IC_CMP, IC_AND: begin
                            state   <= S_GET_A;
                            rnum_q  <= rn;
                            loada_q <= 1'b1;
                        end
                        default: begin
                            state   <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    endcase
                end
                S_GET_A: begin
                    state   <= S_GET_B;
                    rnum_q  <= rm;
                    loadb_q <= 1'b1;
                end
                S_GET_B: begin
                    state   <= S_EXEC;
                    shift_q <= sh;
                    aluop_q <= op;
                    loadc_q <= 1'b1;
                    // MOV reg and MVN pass B through the ALU with a zeroed A operand
                    if (cls == IC_MOV_REG) begin
                        aluop_q <= ALU_ADD;
                        asel_q  <= 1'b1;
                    end else if (cls == IC_MVN) begin
                        asel_q  <= 1'b1;
                    end else if (cls == IC_CMP) begin
                        loadc_q <= 1'b0;
                        loads_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cls == IC_CMP) begin
                        state   <= S_WAIT;
                        w_q     <= 1'b1;
                    end else begin
                        state   <= S_WR_REG;
                        rnum_q  <= rd;
                        vsel_q  <= VSEL_C;
                        write_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    w_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.w      = w_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.rnum   = rnum_q;
    assign bus.write  = write_q;
    assign bus.vsel   = vsel_q;
    assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign bus.loada  = loada_q;
    assign bus.loadb  = loadb_q;
    assign bus.loadc  = loadc_q;
    assign bus.loads  = loads_q;
    assign bus.asel   = asel_q;
    assign bus.shift  = shift_q;
    assign bus.ALUop  = aluop_q;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Self-checking bench for dp_seq_ctrl: directed scenarios plus random instructions
// compared cycle by cycle against a table-driven model of the instruction timing.
module tb_dp_seq_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dp_seq_ctrl_if bus ();

    dp_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {w,done,err,write,loada,loadb,loadc,loads,asel,rnum[2:0],vsel[1:0],shift[1:0],ALUop[1:0]}
    function automatic logic [17:0] pack(input logic w, done, err, write, la, lb, lc, ls, asel,
                                         input logic [2:0] rnum, input logic [1:0] vsel, shift, aluop);
        return {w, done, err, write, la, lb, lc, ls, asel, rnum, vsel, shift, aluop};
    endfunction

    function automatic logic [17:0] observed();
        return pack(bus.w, bus.done, bus.err, bus.write, bus.loada, bus.loadb, bus.loadc,
                    bus.loads, bus.asel, bus.rnum, bus.vsel, bus.shift, bus.ALUop);
    endfunction

    // Reference model: classify by opcode/op, then describe each cycle after capture.
    function automatic int latency(input logic [15:0] i);
        logic [2:0] opc;
        logic [1:0] op;
        opc = i[15:13];
        op  = i[12:11];
        if (opc == 3'b110 && op == 2'b10) return 2;
        if (opc == 3'b110 && op == 2'b00) return 4;
        if (opc == 3'b101 && (op == 2'b11 || op == 2'b01)) return 4;
        if (opc == 3'b101) return 5;
        return 2;
    endfunction

    function automatic logic [17:0] expected(input logic [15:0] i, input int k);
        logic [2:0] opc;
        logic [1:0] op;
        logic [2:0] rn, rd, rm;
        logic [1:0] sh;
        bit legal, movimm, movreg, mvn, cmp, two_op;
        int exec_k;
        opc = i[15:13]; op = i[12:11];
        rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
        movimm = (opc == 3'b110 && op == 2'b10);
        movreg = (opc == 3'b110 && op == 2'b00);
        mvn    = (opc == 3'b101 && op == 2'b11);
        cmp    = (opc == 3'b101 && op == 2'b01);
        two_op = (opc == 3'b101 && op != 2'b11);
        legal  = movimm || movreg || (opc == 3'b101);
        exec_k = two_op ? 4 : 3;
        if (k == 1) return '0;
        if (!legal) return pack(0,0,1,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0);
        if (movimm) return pack(0,1,0,1,0,0,0,0,0, rn, 2'b01, 2'd0, 2'd0);
        if (two_op && k == 2) return pack(0,0,0,0,1,0,0,0,0, rn, 2'd0, 2'd0, 2'd0);
        if (k == exec_k - 1) return pack(0,0,0,0,0,1,0,0,0, rm, 2'd0, 2'd0, 2'd0);
        if (k == exec_k) begin
            if (cmp)    return pack(0,1,0,0,0,0,0,1,0, 3'd0, 2'd0, sh, op);
            if (movreg) return pack(0,0,0,0,0,0,1,0,1, 3'd0, 2'd0, sh, 2'b00);
            if (mvn)    return pack(0,0,0,0,0,0,1,0,1, 3'd0, 2'd0, sh, op);
            return pack(0,0,0,0,0,0,1,0,0, 3'd0, 2'd0, sh, op);
        end
        return pack(0,1,0,1,0,0,0,0,0, rd, 2'b00, 2'd0, 2'd0);
    endfunction

    // Issue one instruction from WAIT and follow it to the WAIT cycle after done.
    // abort_k > 0 stops after checking that cycle (used for mid-instruction reset).
    task automatic drive_and_check_instr(input logic [15:0] i, input bit hold, input int abort_k);
        int lat;
        logic [15:0] imm;
        lat = latency(i);
        imm = {{8{i[7]}}, i[7:0]};
        checks++;
        if (bus.w !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_issue instr=%h w=%b required 1", i, bus.w);
        end
        bus.start = 1'b1;
        bus.instr = i;
        @(posedge clk);
        #1;
        bus.start = hold;
        bus.instr = 16'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k == lat) bus.start = 1'b0;
            checks++;
            if (observed() !== expected(i, k)) begin
                errors++;
                $display("FAIL cycle instr=%h k=%0d got=%h required=%h", i, k, observed(), expected(i, k));
            end
            checks++;
            if (bus.sximm8 !== imm) begin
                errors++;
                $display("FAIL sximm8 instr=%h k=%0d got=%h required=%h", i, k, bus.sximm8, imm);
            end
            if (k == abort_k) return;
            @(posedge clk);
            #1;
        end
        checks++;
        if (observed() !== pack(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
            errors++;
            $display("FAIL wait_after_done instr=%h got=%h required=%h", i, observed(),
                     pack(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.instr = 16'hD3FE;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (observed() !== pack(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=%h", observed(),
                     pack(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0));
        end
        checks++;
        if (bus.sximm8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sximm8 got=%h required=0000", bus.sximm8);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_mov_imm();
        drive_and_check_instr(16'hD3FE, 1'b0, 0);
    endtask

    task automatic test_add_start_held();
        drive_and_check_instr(16'hA148, 1'b1, 0);
    endtask

    task automatic test_cmp();
        drive_and_check_instr(16'hA900, 1'b0, 0);
    endtask

    task automatic test_illegal();
        drive_and_check_instr(16'hE000, 1'b0, 0);
    endtask

    task automatic test_reset_mid_instr();
        drive_and_check_instr(16'hA148, 1'b0, 3);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== pack(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0) || bus.sximm8 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got=%h sximm8=%h required=%h sximm8=0000", observed(), bus.sximm8,
                     pack(1,0,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0));
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.write !== 1'b0 || bus.w !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold write=%b w=%b required write=0 w=1", bus.write, bus.w);
            end
        end
        rst_n = 1'b1;
        drive_and_check_instr(16'hB885, 1'b0, 0);
    endtask

    task automatic test_back_to_back_random();
        logic [15:0] i;
        for (int n = 0; n < 60; n++) begin
            i = 16'($urandom);
            // bias towards legal opcodes so every class is exercised
            if ($urandom_range(0, 3) != 0) i[15:13] = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110;
            drive_and_check_instr(i, 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) != 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.instr = 16'h0000;
        test_reset();
        test_mov_imm();
        test_add_start_held();
        test_cmp();
        test_illegal();
        test_reset_mid_instr();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
